// File: rtl/stack_exec_if.sv
// stack_exec_if: command/result handshake plus the attached-stack port bundle
interface stack_exec_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 3
);
    localparam int OW = $clog2(DEPTH + 1);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic [WIDTH-1:0] cmd_imm;
    logic             res_valid;
    logic [WIDTH-1:0] res_data;
    logic             res_err;
    logic [OW-1:0]    occupancy;
    logic             s_push;
    logic             s_pop;
    logic [WIDTH-1:0] s_data_in;
    logic [WIDTH-1:0] s_data_out;
    logic             s_full;
    logic             s_empty;
    modport master (
        output cmd_valid, cmd_op, cmd_imm, s_data_out, s_full, s_empty,
        input  cmd_ready, res_valid, res_data, res_err, occupancy, s_push, s_pop, s_data_in
    );
    modport slave (
        input  cmd_valid, cmd_op, cmd_imm, s_data_out, s_full, s_empty,
        output cmd_ready, res_valid, res_data, res_err, occupancy, s_push, s_pop, s_data_in
    );
endinterface

// File: rtl/stack_exec.sv
// stack_exec: executes push/pop/ALU/dup commands against an external registered stack
module stack_exec #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 3
) (
    input logic         clk,
    input logic         rst,
    stack_exec_if.slave bus
);
    localparam int OW = $clog2(DEPTH + 1);
    localparam logic [2:0] OP_PUSH = 3'd0, OP_POP = 3'd1, OP_ADD = 3'd2, OP_SUB = 3'd3;
    localparam logic [2:0] OP_AND = 3'd4, OP_OR = 3'd5, OP_XOR = 3'd6, OP_DUP = 3'd7;
    typedef enum logic [2:0] {IDLE, POP_A, CAP_A, POP_B, CAP_B, PUSH1, PUSH2, DONE} state_t;
    state_t           state_q, state_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] imm_q, imm_d, a_q, a_d, b_q, b_d, res_q, res_d, push_w;
    logic             err_q, err_d;
    logic [OW-1:0]    occ_q, occ_d;
    logic [1:0]       need;
    logic             is_bin, under, over;
    assign is_bin = bus.cmd_op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR};
    assign need   = (bus.cmd_op == OP_POP || bus.cmd_op == OP_DUP) ? 2'd1 : is_bin ? 2'd2 : 2'd0;
    assign under  = need != 2'd0 && (32'(need) > 32'(occ_q) || bus.s_empty);
    assign over   = (bus.cmd_op == OP_PUSH || bus.cmd_op == OP_DUP) && (occ_q == OW'(DEPTH) || bus.s_full);
    assign bus.occupancy = occ_q;
    // state and datapath registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            op_q    <= '0;
            imm_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            err_q   <= 1'b0;
            occ_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            imm_q   <= imm_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            err_q   <= err_d;
            occ_q   <= occ_d;
        end
    end
    // word written in PUSH1: immediate, B op A, or A for DUP
    always_comb begin
        case (op_q)
            OP_PUSH: push_w = imm_q;
            OP_ADD:  push_w = b_q + a_q;
            OP_SUB:  push_w = b_q - a_q;
            OP_AND:  push_w = b_q & a_q;
            OP_OR:   push_w = b_q | a_q;
            OP_XOR:  push_w = b_q ^ a_q;
            default: push_w = a_q;
        endcase
    end
    // sequencing of stack strobes, operand capture and the completion pulse
    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        imm_d         = imm_q;
        a_d           = a_q;
        b_d           = b_q;
        res_d         = res_q;
        err_d         = err_q;
        occ_d         = occ_q;
        bus.cmd_ready = 1'b0;
        bus.res_valid = 1'b0;
        bus.res_data  = '0;
        bus.res_err   = 1'b0;
        bus.s_push    = 1'b0;
        bus.s_pop     = 1'b0;
        bus.s_data_in = '0;
        unique case (state_q)
            IDLE: begin
                bus.cmd_ready = 1'b1;
                if (bus.cmd_valid) begin
                    op_d    = bus.cmd_op;
                    imm_d   = bus.cmd_imm;
                    err_d   = under | over;
                    res_d   = '0;
                    state_d = (under | over) ? DONE : bus.cmd_op == OP_PUSH ? PUSH1 : POP_A;
                end
            end
            POP_A: begin
                bus.s_pop = 1'b1;
                occ_d     = occ_q - OW'(1);
                state_d   = CAP_A;
            end
            CAP_A: begin
                a_d     = bus.s_data_out;
                res_d   = bus.s_data_out;
                state_d = op_q == OP_POP ? DONE : op_q == OP_DUP ? PUSH1 : POP_B;
            end
            POP_B: begin
                bus.s_pop = 1'b1;
                occ_d     = occ_q - OW'(1);
                state_d   = CAP_B;
            end
            CAP_B: begin
                b_d     = bus.s_data_out;
                state_d = PUSH1;
            end
            PUSH1: begin
                bus.s_push    = 1'b1;
                bus.s_data_in = push_w;
                res_d         = push_w;
                occ_d         = occ_q + OW'(1);
                state_d       = op_q == OP_DUP ? PUSH2 : DONE;
            end
            PUSH2: begin
                bus.s_push    = 1'b1;
                bus.s_data_in = a_q;
                occ_d         = occ_q + OW'(1);
                state_d       = DONE;
            end
            DONE: begin
                bus.res_valid = 1'b1;
                bus.res_data  = res_q;
                bus.res_err   = err_q;
                state_d       = IDLE;
            end
        endcase
    end
endmodule

// File: doc/stack_exec.md
STACK_EXEC -- requirements
Module: stack_exec

Interface
REQ-001 SHALL have parameter WIDTH, default 8: data word width in bits.
REQ-002 SHALL have parameter DEPTH, default 3: number of entries in the attached stack.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port cmd_valid, input, 1: command offered.
REQ-006 SHALL have port cmd_ready, output, 1: command accepted when cmd_valid and cmd_ready are high at a clock edge.
REQ-007 SHALL have port cmd_op, input, 3: operation code.
REQ-008 SHALL have port cmd_imm, input, WIDTH: immediate operand for PUSH.
REQ-009 SHALL have port res_valid, output, 1: one-cycle completion pulse.
REQ-010 SHALL have port res_data, output, WIDTH: result word; valid while res_valid is high.
REQ-011 SHALL have port res_err, output, 1: command rejected; valid while res_valid is high.
REQ-012 SHALL have port occupancy, output, $clog2(DEPTH+1): tracked stack entry count.
REQ-013 SHALL have port s_push, output, 1: stack push strobe.
REQ-014 SHALL have port s_pop, output, 1: stack pop strobe.
REQ-015 SHALL have port s_data_in, output, WIDTH: word to push.
REQ-016 SHALL have port s_data_out, input, WIDTH: popped word; registered by the stack, valid the cycle after s_pop is sampled.
REQ-017 SHALL have ports s_full and s_empty, input, 1 each: stack status flags.

Function
REQ-018 SHALL decode opcodes as: 000 PUSH imm; 001 POP; 010 ADD; 011 SUB; 100 AND; 101 OR; 110 XOR; 111 DUP.
REQ-019 SHALL use FSM states IDLE, POP_A, CAP_A, POP_B, CAP_B, PUSH1, PUSH2, DONE; cmd_ready SHALL be 1 only in IDLE.
REQ-020 PUSH SHALL follow IDLE->PUSH1->DONE; PUSH1 drives s_push=1 and s_data_in=cmd_imm; res_data=cmd_imm.
REQ-021 POP SHALL follow IDLE->POP_A->CAP_A->DONE; POP_A drives s_pop=1; CAP_A latches s_data_out into A; res_data=A.
REQ-022 Binary ops SHALL follow IDLE->POP_A->CAP_A->POP_B->CAP_B->PUSH1->DONE: A=top, B=next; PUSH1 pushes B op A; res_data=the pushed word.
REQ-023 SUB SHALL compute B-A; ADD/SUB SHALL wrap modulo 2^WIDTH with no carry or borrow output.
REQ-024 DUP SHALL follow IDLE->POP_A->CAP_A->PUSH1->PUSH2->DONE, pushing A twice; res_data=A.
REQ-025 res_valid SHALL be high exactly one cycle, in DONE; DONE SHALL return to IDLE.
REQ-026 Latency from the accept edge to res_valid SHALL be 2 cycles for PUSH, 3 for POP, 6 for binary ops, and 5 for DUP.
REQ-027 s_push and s_pop SHALL each be at most one-cycle pulses and SHALL never be high in the same cycle.
REQ-028 Underflow SHALL be flagged on accept if required operands exceed occupancy, or if s_empty=1, where POP/DUP need 1 operand and binary ops need 2.
REQ-029 Overflow SHALL be flagged on accept for PUSH or DUP when occupancy==DEPTH or s_full=1.
REQ-030 On an error, the block SHALL go directly IDLE->DONE with no s_push or s_pop, res_err=1, res_data=0, and occupancy unchanged.
REQ-031 occupancy SHALL increment on each s_push cycle and decrement on each s_pop cycle.
REQ-032 Net occupancy change SHALL be +1 for PUSH, -1 for POP, -1 for binary ops, and +1 for DUP.
REQ-033 cmd_op and cmd_imm SHALL be captured at accept; later input changes SHALL not affect the command in flight.

Reset
REQ-034 While rst=0, the block SHALL asynchronously force: state IDLE, cmd_ready=1, res_valid=0, res_err=0, res_data=0, occupancy=0, s_push=0, s_pop=0, s_data_in=0, A=0, B=0.
REQ-035 Reset mid-command SHALL abandon the command with no further stack strobes; the bench SHALL reset the attached stack in the same cycle so that occupancy matches.
REQ-036 On the first edge after rst releases, the block SHALL accept a command.

Verification (WIDTH=8, DEPTH=3)
REQ-037 Scenario, reset: hold rst=0 -> cmd_ready=1, res_valid=0, s_push=0, s_pop=0, occupancy=0.
REQ-038 Scenario, SUB: PUSH 0x05, PUSH 0x03, SUB -> res_data=0x02, res_err=0, occupancy=1, res_valid 6 cycles after SUB is accepted.
REQ-039 Scenario, wrap: PUSH 0x03, PUSH 0x05, SUB -> 0xFE; then PUSH 0xFF, PUSH 0x02, ADD -> 0x01.
REQ-040 Scenario, full: PUSH 0xAA, 0xBB, 0xCC -> occupancy=3; PUSH 0xDD -> res_err=1 with no s_push; DUP -> res_err=1; POP -> res_data=0xCC.
REQ-041 Scenario, underflow: with occupancy=1, ADD -> res_err=1, no s_pop, occupancy=1; DUP -> res_data equal to the top value, occupancy=2.
REQ-042 Scenario, reset mid-command: drive rst=0 during CAP_A of an ADD -> outputs take reset values immediately; after release, PUSH 0x11 then POP -> 0x11.
